// File: rtl/ham.sv
// Hamming(7,4) single-error-correcting codec stage; encoder always present, decoder optional.
// Latency: 1 clk from in_vld/rx_vld to out_vld/dec_vld; one codeword per cycle on each path.
// Backpressure: none, every valid input is accepted; data outputs hold between valid cycles.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_dat/in_vld     4-bit nibble to encode (bit0=d1 .. bit3=d4)
//   true_dat/out_vld  7-bit codeword, bit i = codeword position i+1
//   rx_dat/rx_vld     received codeword            (HAM_DECODE_EN only)
//   dec_dat/dec_syn/dec_err/dec_vld  corrected nibble, syndrome {s4,s2,s1},
//                     nonzero-syndrome flag, valid (HAM_DECODE_EN only)
//
// Build option: define HAM_DECODE_EN to compile in the decoder and its ports.
module ham (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_dat,
  input  logic       in_vld,
  output logic [6:0] true_dat,
  output logic       out_vld
`ifdef HAM_DECODE_EN
  ,
  input  logic [6:0] rx_dat,
  input  logic       rx_vld,
  output logic [3:0] dec_dat,
  output logic [2:0] dec_syn,
  output logic       dec_err,
  output logic       dec_vld
`endif
);

  // ---------------------------------------------------------------- encoder
  // Codeword positions 1..7 = p1 p2 d1 p4 d2 d3 d4, even parity.
  logic [6:0] w_cw;
  logic [6:0] r_true_dat;
  logic       r_out_vld;

  always_comb begin
    w_cw    = '0;
    w_cw[0] = in_dat[0] ^ in_dat[1] ^ in_dat[3];  // p1
    w_cw[1] = in_dat[0] ^ in_dat[2] ^ in_dat[3];  // p2
    w_cw[2] = in_dat[0];                          // d1
    w_cw[3] = in_dat[1] ^ in_dat[2] ^ in_dat[3];  // p4
    w_cw[4] = in_dat[1];                          // d2
    w_cw[5] = in_dat[2];                          // d3
    w_cw[6] = in_dat[3];                          // d4
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_true_dat <= '0;
      r_out_vld  <= 1'b0;
    end else begin
      r_out_vld <= in_vld;
      if (in_vld) begin
        r_true_dat <= w_cw;
      end
    end
  end

  assign true_dat = r_true_dat;
  assign out_vld  = r_out_vld;

`ifdef HAM_DECODE_EN
  // ---------------------------------------------------------------- decoder
  logic [2:0] w_syn;
  logic [6:0] w_flip;
  logic [6:0] w_fix;
  logic [3:0] r_dec_dat;
  logic [2:0] r_dec_syn;
  logic       r_dec_err;
  logic       r_dec_vld;

  always_comb begin
    w_syn[0] = rx_dat[0] ^ rx_dat[2] ^ rx_dat[4] ^ rx_dat[6];  // s1: positions 1,3,5,7
    w_syn[1] = rx_dat[1] ^ rx_dat[2] ^ rx_dat[5] ^ rx_dat[6];  // s2: positions 2,3,6,7
    w_syn[2] = rx_dat[3] ^ rx_dat[4] ^ rx_dat[5] ^ rx_dat[6];  // s4: positions 4,5,6,7
    // The syndrome names the erroneous position directly; position n is bit n-1.
    w_flip = '0;
    if (w_syn != 3'd0) begin
      w_flip = 7'b000_0001 << (w_syn - 3'd1);
    end
    w_fix = rx_dat ^ w_flip;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dec_dat <= '0;
      r_dec_syn <= '0;
      r_dec_err <= 1'b0;
      r_dec_vld <= 1'b0;
    end else begin
      r_dec_vld <= rx_vld;
      if (rx_vld) begin
        r_dec_dat <= {w_fix[6], w_fix[5], w_fix[4], w_fix[2]};
        r_dec_syn <= w_syn;
        r_dec_err <= (w_syn != 3'd0);
      end
    end
  end

  assign dec_dat = r_dec_dat;
  assign dec_syn = r_dec_syn;
  assign dec_err = r_dec_err;
  assign dec_vld = r_dec_vld;
`endif

endmodule

// File: tb/tb_ham.sv
// Testbench for ham: directed vectors plus randomized traffic against a
// reference model built from Hamming position rules.
// Decoder scenarios run when HAM_DECODE_EN is defined for the build.
module tb_ham;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_dat;
  logic       in_vld;
  logic [6:0] true_dat;
  logic       out_vld;
`ifdef HAM_DECODE_EN
  logic [6:0] rx_dat;
  logic       rx_vld;
  logic [3:0] dec_dat;
  logic [2:0] dec_syn;
  logic       dec_err;
  logic       dec_vld;
`endif

  int vectors     = 0;
  int miscompares = 0;

  ham dut (
    .clk      (clk),
    .rst      (rst),
    .in_dat   (in_dat),
    .in_vld   (in_vld),
    .true_dat (true_dat),
    .out_vld  (out_vld)
`ifdef HAM_DECODE_EN
    ,
    .rx_dat   (rx_dat),
    .rx_vld   (rx_vld),
    .dec_dat  (dec_dat),
    .dec_syn  (dec_syn),
    .dec_err  (dec_err),
    .dec_vld  (dec_vld)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: data bits occupy the non-power-of-two positions 3,5,6,7;
  // parity bit at position p covers every other position whose index has bit p set.
  function automatic logic [6:0] model_cw(input logic [3:0] d);
    logic [7:1] cw;
    int         dpos [4];
    logic [6:0] r;
    dpos[0] = 3; dpos[1] = 5; dpos[2] = 6; dpos[3] = 7;
    cw = '0;
    for (int i = 0; i < 4; i++) cw[dpos[i]] = d[i];
    for (int p = 1; p <= 4; p = p * 2) begin
      logic x;
      x = 1'b0;
      for (int j = 1; j <= 7; j++)
        if (j != p && (j & p) != 0) x = x ^ cw[j];
      cw[p] = x;
    end
    for (int j = 1; j <= 7; j++) r[j-1] = cw[j];
    return r;
  endfunction

  // Advance to just after the next rising edge: inputs driven here are
  // captured on the following edge, and outputs sampled here are settled.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_dat = 4'hF; in_vld = 1'b1;
`ifdef HAM_DECODE_EN
    rx_dat = 7'h55; rx_vld = 1'b1;
`endif
    #2;
    repeat (2) cyc;
    vectors++;
    if (true_dat !== 7'd0 || out_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: true_dat=%b out_vld=%b, want 0/0", true_dat, out_vld);
    end
`ifdef HAM_DECODE_EN
    vectors++;
    if (dec_dat !== 4'd0 || dec_syn !== 3'd0 || dec_err !== 1'b0 || dec_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dec: dat=%b syn=%b err=%b vld=%b, want all 0", dec_dat, dec_syn, dec_err, dec_vld);
    end
    rx_vld = 1'b0;
`endif
    rst = 1'b0;
    #1;
    vectors++;
    if (true_dat !== 7'd0 || out_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: true_dat=%b out_vld=%b before first edge, want 0/0", true_dat, out_vld);
    end
    cyc;
    vectors++;
    if (true_dat !== 7'b1111111 || out_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_capture: true_dat=%b out_vld=%b, want 1111111/1", true_dat, out_vld);
    end
  endtask

  task automatic test_encode_vectors;
    logic [3:0] nib [5];
    logic [6:0] exp [5];
    nib[0] = 4'b1111; exp[0] = 7'b1111111;
    nib[1] = 4'b0000; exp[1] = 7'b0000000;
    nib[2] = 4'b0001; exp[2] = 7'b0000111;
    nib[3] = 4'b0101; exp[3] = 7'b0101101;
    nib[4] = 4'b1000; exp[4] = 7'b1001011;
    for (int i = 0; i < 5; i++) begin
      in_dat = nib[i]; in_vld = 1'b1;
      cyc;
      vectors++;
      if (true_dat !== exp[i] || out_vld !== 1'b1) begin
        miscompares++;
        $display("FAIL encode_vec%0d: in=%b got %b/%b, want %b/1", i, nib[i], true_dat, out_vld, exp[i]);
      end
    end
  endtask

  // Assumes the last loaded codeword is that of 4'b1000.
  task automatic test_hold;
    in_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_dat = 4'($urandom);
      cyc;
      vectors++;
      if (true_dat !== 7'b1001011 || out_vld !== 1'b0) begin
        miscompares++;
        $display("FAIL hold%0d: got %b/%b, want 1001011/0", i, true_dat, out_vld);
      end
    end
  endtask

  task automatic test_random_encode;
    logic [6:0] exp_cw;
    logic       exp_vld;
    exp_cw = true_dat === 7'b1001011 ? 7'b1001011 : model_cw(4'b1000);
    for (int i = 0; i < 60; i++) begin
      in_dat = 4'($urandom);
      in_vld = 1'($urandom_range(0, 1));
      exp_vld = in_vld;
      if (in_vld) exp_cw = model_cw(in_dat);
      cyc;
      vectors++;
      if (true_dat !== exp_cw || out_vld !== exp_vld) begin
        miscompares++;
        $display("FAIL rand_encode%0d: got %b/%b, want %b/%b", i, true_dat, out_vld, exp_cw, exp_vld);
      end
    end
    in_vld = 1'b0;
  endtask

  task automatic test_async_reset;
    in_dat = 4'hF; in_vld = 1'b1;
    cyc;
    in_dat = 4'h5;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (true_dat !== 7'd0 || out_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: true_dat=%b out_vld=%b, want 0/0", true_dat, out_vld);
    end
    cyc;
    rst = 1'b0; in_vld = 1'b0;
    cyc;
    vectors++;
    if (true_dat !== 7'd0 || out_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_drop: true_dat=%b out_vld=%b, want 0/0", true_dat, out_vld);
    end
  endtask

`ifdef HAM_DECODE_EN
  task automatic test_decode_clean;
    rx_dat = model_cw(4'b0101); rx_vld = 1'b1;
    cyc;
    rx_vld = 1'b0;
    vectors++;
    if (dec_dat !== 4'b0101 || dec_syn !== 3'd0 || dec_err !== 1'b0 || dec_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL dec_clean: dat=%b syn=%0d err=%b vld=%b, want 0101/0/0/1", dec_dat, dec_syn, dec_err, dec_vld);
    end
  endtask

  task automatic test_decode_single;
    rx_dat = 7'b1001111; rx_vld = 1'b1;
    cyc;
    rx_vld = 1'b0;
    vectors++;
    if (dec_dat !== 4'b1000 || dec_syn !== 3'd3 || dec_err !== 1'b1 || dec_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL dec_single: dat=%b syn=%0d err=%b vld=%b, want 1000/3/1/1", dec_dat, dec_syn, dec_err, dec_vld);
    end
  endtask

  task automatic test_all_flips;
    logic [6:0] m;
    for (int n = 0; n < 16; n++) begin
      for (int p = 1; p <= 7; p++) begin
        m = 7'b000_0001 << (p - 1);
        rx_dat = model_cw(4'(n)) ^ m; rx_vld = 1'b1;
        cyc;
        vectors++;
        if (dec_dat !== 4'(n) || dec_syn !== 3'(p) || dec_err !== 1'b1 || dec_vld !== 1'b1) begin
          miscompares++;
          $display("FAIL flip n=%0d pos=%0d: dat=%b syn=%0d err=%b vld=%b", n, p, dec_dat, dec_syn, dec_err, dec_vld);
        end
      end
    end
    rx_vld = 1'b0;
  endtask

  // Two flips: syndrome is the XOR of the two positions, never zero.
  task automatic test_double_error;
    int a, b;
    logic [6:0] m;
    for (int i = 0; i < 10; i++) begin
      a = $urandom_range(1, 7);
      b = $urandom_range(1, 6);
      if (b >= a) b = b + 1;
      m = (7'b000_0001 << (a - 1)) | (7'b000_0001 << (b - 1));
      rx_dat = model_cw(4'($urandom)) ^ m; rx_vld = 1'b1;
      cyc;
      vectors++;
      if (dec_syn !== 3'(a ^ b) || dec_err !== 1'b1 || dec_vld !== 1'b1) begin
        miscompares++;
        $display("FAIL double%0d pos %0d,%0d: syn=%0d err=%b, want %0d/1", i, a, b, dec_syn, dec_err, a ^ b);
      end
    end
    rx_vld = 1'b0;
  endtask

  task automatic test_concurrent;
    logic [3:0] ne, nd;
    int         p;
    logic [6:0] m;
    for (int i = 0; i < 8; i++) begin
      ne = 4'($urandom); nd = 4'($urandom); p = $urandom_range(0, 7);
      m = (p == 0) ? 7'd0 : (7'b000_0001 << (p - 1));
      in_dat = ne; in_vld = 1'b1;
      rx_dat = model_cw(nd) ^ m; rx_vld = 1'b1;
      cyc;
      vectors++;
      if (true_dat !== model_cw(ne) || out_vld !== 1'b1 || dec_dat !== nd ||
          dec_syn !== 3'(p) || dec_err !== (p != 0) || dec_vld !== 1'b1) begin
        miscompares++;
        $display("FAIL concurrent%0d: enc=%b/%b dec=%b syn=%0d err=%b vld=%b, want %b/1 %b/%0d/%b/1",
                 i, true_dat, out_vld, dec_dat, dec_syn, dec_err, dec_vld, model_cw(ne), nd, p, p != 0);
      end
      in_vld = 1'b0; rx_vld = 1'b0;
      in_dat = ~ne; rx_dat = 7'($urandom);
      cyc;
      vectors++;
      if (true_dat !== model_cw(ne) || out_vld !== 1'b0 || dec_dat !== nd || dec_vld !== 1'b0) begin
        miscompares++;
        $display("FAIL concurrent_hold%0d: enc=%b/%b dec=%b/%b, want %b/0 %b/0",
                 i, true_dat, out_vld, dec_dat, dec_vld, model_cw(ne), nd);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_dat = '0; in_vld = 1'b0;
`ifdef HAM_DECODE_EN
    rx_dat = '0; rx_vld = 1'b0;
`endif
    test_reset;
    test_encode_vectors;
    test_hold;
    test_random_encode;
    test_async_reset;
`ifdef HAM_DECODE_EN
    test_decode_clean;
    test_decode_single;
    test_all_flips;
    test_double_error;
    test_concurrent;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
